// File: rtl/srio_ireq_arbiter.sv
// Packet-granular round-robin arbiter sharing the SRIO ireq AXI-Stream channel
// between NUM_REQ local requesters. A grant is held from the first beat to tlast.
// New grants are issued only while the port reports initialized. Per-requester
// forwarded-packet counters wrap silently.

// Per-requester packet counter, instantiated once per lane.
module srio_ireq_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q;

  // Count one per completed packet; natural overflow gives the wrap to zero.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)     cnt_q <= '0;
    else if (inc_i) cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;
endmodule

module srio_ireq_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_port_initialized,
  input  logic [NUM_REQ-1:0]       s_ireq_tvalid,
  output logic [NUM_REQ-1:0]       s_ireq_tready,
  input  logic [NUM_REQ-1:0]       s_ireq_tlast,
  input  logic [NUM_REQ*64-1:0]    s_ireq_tdata,
  input  logic [NUM_REQ*8-1:0]     s_ireq_tkeep,
  input  logic [NUM_REQ*32-1:0]    s_ireq_tuser,
  output logic                     m_axis_ireq_tvalid,
  input  logic                     m_axis_ireq_tready,
  output logic                     m_axis_ireq_tlast,
  output logic [63:0]              m_axis_ireq_tdata,
  output logic [7:0]               m_axis_ireq_tkeep,
  output logic [31:0]              m_axis_ireq_tuser,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic                     o_busy,
  output logic [NUM_REQ*CNT_W-1:0] o_pkt_cnt
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, XFER} state_e;

  state_e                             state_q, state_d;
  logic [PTR_W-1:0]                   gidx_q, gidx_d;
  logic [PTR_W-1:0]                   ptr_q, ptr_d;
  logic [NUM_REQ-1:0]                 grant_q, grant_d;
  logic [NUM_REQ-1:0]                 inc;
  logic [PTR_W-1:0]                   sel, idx_c;
  logic                               found;
  int                                 idx;
  logic                               pkt_done;

  // Flat buses viewed per requester.
  logic [NUM_REQ-1:0][63:0] req_data;
  logic [NUM_REQ-1:0][7:0]  req_keep;
  logic [NUM_REQ-1:0][31:0] req_user;
  assign req_data = s_ireq_tdata;
  assign req_keep = s_ireq_tkeep;
  assign req_user = s_ireq_tuser;

  // Round-robin pick: first valid requester scanning ptr, ptr+1, ... modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    idx_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_c = PTR_W'(idx);
      if (!found && s_ireq_tvalid[idx_c]) begin
        found = 1'b1;
        sel   = idx_c;
      end
    end
  end

  // Packet ends when the granted requester's tlast beat is accepted downstream.
  assign pkt_done = (state_q == XFER) && s_ireq_tvalid[gidx_q] &&
                    m_axis_ireq_tready && s_ireq_tlast[gidx_q];

  // State and arbitration registers; reset abandons any packet in flight.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  // Next state: lock a requester from IDLE, release it after its tlast beat.
  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    inc     = '0;
    case (state_q)
      IDLE: begin
        if (i_port_initialized && found) begin
          state_d = XFER;
          gidx_d  = sel;
          grant_d = NUM_REQ'(1) << sel;
        end
      end
      XFER: begin
        if (pkt_done) begin
          state_d     = IDLE;
          grant_d     = '0;
          inc[gidx_q] = 1'b1;
          ptr_d       = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: zero-latency mux of the granted requester while locked, else all zero.
  always_comb begin
    m_axis_ireq_tvalid = 1'b0;
    m_axis_ireq_tlast  = 1'b0;
    m_axis_ireq_tdata  = '0;
    m_axis_ireq_tkeep  = '0;
    m_axis_ireq_tuser  = '0;
    s_ireq_tready      = '0;
    if (state_q == XFER) begin
      m_axis_ireq_tvalid    = s_ireq_tvalid[gidx_q];
      m_axis_ireq_tlast     = s_ireq_tlast[gidx_q];
      m_axis_ireq_tdata     = req_data[gidx_q];
      m_axis_ireq_tkeep     = req_keep[gidx_q];
      m_axis_ireq_tuser     = req_user[gidx_q];
      s_ireq_tready[gidx_q] = m_axis_ireq_tready;
    end
  end

  assign o_grant = grant_q;
  assign o_busy  = (state_q == XFER);

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_cnt
    srio_ireq_cnt #(.CNT_W(CNT_W)) u_cnt (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .inc_i (inc[r]),
      .cnt_o (o_pkt_cnt[r*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_srio_ireq_arbiter.sv
// Bench for srio_ireq_arbiter: queue-driven AXI-S requesters, a behavioural
// owner/pointer/counter model checked every cycle, and directed scenarios.
module tb_srio_ireq_arbiter;
  localparam int NR = 2;
  localparam int CW = 4;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic [31:0] u;
    logic        l;
    int          gap;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 rst, init;
  logic [NR-1:0]        s_tvalid, s_tready, s_tlast;
  logic [NR-1:0][63:0]  s_tdata;
  logic [NR-1:0][7:0]   s_tkeep;
  logic [NR-1:0][31:0]  s_tuser;
  logic                 m_tvalid, m_tready, m_tlast;
  logic [63:0]          m_tdata;
  logic [7:0]           m_tkeep;
  logic [31:0]          m_tuser;
  logic [NR-1:0]        o_grant;
  logic                 o_busy;
  logic [NR*CW-1:0]     o_pkt_cnt;

  srio_ireq_arbiter #(.NUM_REQ(NR), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_port_initialized(init),
    .s_ireq_tvalid(s_tvalid), .s_ireq_tready(s_tready), .s_ireq_tlast(s_tlast),
    .s_ireq_tdata(s_tdata), .s_ireq_tkeep(s_tkeep), .s_ireq_tuser(s_tuser),
    .m_axis_ireq_tvalid(m_tvalid), .m_axis_ireq_tready(m_tready),
    .m_axis_ireq_tlast(m_tlast), .m_axis_ireq_tdata(m_tdata),
    .m_axis_ireq_tkeep(m_tkeep), .m_axis_ireq_tuser(m_tuser),
    .o_grant(o_grant), .o_busy(o_busy), .o_pkt_cnt(o_pkt_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Requester-side stimulus state
  beat_t         txq[NR][$];
  beat_t         expq[NR][$];
  int            gapc[NR];
  logic [NR-1:0] armed = '0;
  logic [NR-1:0] acc = '0;
  logic          flush = 1'b0;
  int            ready_pct = 100;

  task automatic load_pkt(input int r, input int n, input logic [63:0] base,
                          input int gmax, input int mid_gap);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d   = base + 64'(i);
      b.k   = 8'($urandom);
      b.u   = $urandom;
      b.l   = (i == n - 1);
      b.gap = (i == 2) ? mid_gap : int'($urandom_range(gmax));
      txq[r].push_back(b);
      expq[r].push_back(b);
    end
  endtask

  // AXI-S requesters: hold a beat until accepted, optional idle gap before each beat.
  initial begin
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tkeep = '0; s_tuser = '0;
    m_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      m_tready = ($urandom_range(99) < ready_pct);
      for (int r = 0; r < NR; r++) begin
        if (flush) begin
          txq[r].delete(); expq[r].delete();
          s_tvalid[r] = 1'b0; armed[r] = 1'b0;
        end else begin
          if (acc[r]) begin
            void'(txq[r].pop_front());
            s_tvalid[r] = 1'b0; armed[r] = 1'b0;
          end
          if (!s_tvalid[r] && txq[r].size() > 0) begin
            if (!armed[r]) begin gapc[r] = txq[r][0].gap; armed[r] = 1'b1; end
            if (gapc[r] == 0) begin
              s_tvalid[r] = 1'b1;
              s_tdata[r]  = txq[r][0].d;
              s_tkeep[r]  = txq[r][0].k;
              s_tuser[r]  = txq[r][0].u;
              s_tlast[r]  = txq[r][0].l;
            end else gapc[r]--;
          end
        end
      end
    end
  end

  // Behavioural model: who owns the channel, rr pointer, packet counts.
  int            m_owner = -1;
  int            m_ptr = 0;
  int            m_cnt[NR];
  logic          e_tv, e_l;
  logic [63:0]   e_d;
  logic [7:0]    e_k;
  logic [31:0]   e_u;
  logic [NR-1:0] e_rdy, e_gnt;
  beat_t         sb;
  int            c;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_m_tlast", m_tlast, 0);
      chk("rst_m_tdata", m_tdata, 0);
      chk("rst_m_tkeep", m_tkeep, 0);
      chk("rst_m_tuser", m_tuser, 0);
      chk("rst_tready", s_tready, 0);
      chk("rst_grant", o_grant, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_cnt", o_pkt_cnt, 0);
      m_owner = -1; m_ptr = 0;
      for (int r = 0; r < NR; r++) m_cnt[r] = 0;
      acc = '0;
    end else begin
      e_tv = 0; e_l = 0; e_d = 0; e_k = 0; e_u = 0; e_rdy = '0; e_gnt = '0;
      if (m_owner >= 0) begin
        e_tv = s_tvalid[m_owner]; e_l = s_tlast[m_owner];
        e_d = s_tdata[m_owner]; e_k = s_tkeep[m_owner]; e_u = s_tuser[m_owner];
        e_rdy[m_owner] = m_tready; e_gnt[m_owner] = 1'b1;
      end
      chk("m_tvalid", m_tvalid, e_tv);
      chk("m_tlast", m_tlast, e_l);
      chk("m_tdata", m_tdata, e_d);
      chk("m_tkeep", m_tkeep, e_k);
      chk("m_tuser", m_tuser, e_u);
      chk("s_tready", s_tready, e_rdy);
      chk("grant", o_grant, e_gnt);
      chk("busy", o_busy, m_owner >= 0);
      for (int r = 0; r < NR; r++)
        chk("pkt_cnt", o_pkt_cnt[r*CW +: CW], m_cnt[r] % (1 << CW));
      acc = e_rdy & s_tvalid;
      if (m_owner >= 0) begin
        if (e_tv && m_tready) begin
          if (expq[m_owner].size() == 0) chk("sb_extra_beat", 1, 0);
          else begin
            sb = expq[m_owner].pop_front();
            chk("sb_data", m_tdata, sb.d);
            chk("sb_last", m_tlast, sb.l);
          end
          if (e_l) begin
            m_cnt[m_owner]++;
            m_ptr = (m_owner + 1) % NR;
            m_owner = -1;
          end
        end
      end else if (init) begin
        for (int i = 0; i < NR; i++) begin
          c = (m_ptr + i) % NR;
          if (m_owner < 0 && s_tvalid[c]) m_owner = c;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic drain(input string nm, input int maxc);
    int n = 0;
    while ((expq[0].size() + expq[1].size() > 0 || m_owner >= 0) && n < maxc) begin
      cyc(1); n++;
    end
    chk({"drain_timeout_", nm}, n >= maxc, 0);
  endtask

  task automatic wait_grant(input string nm, input int maxc);
    int n = 0;
    while (o_grant == 0 && n < maxc) begin cyc(1); n++; end
    chk({"grant_timeout_", nm}, n >= maxc, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0; cyc(2); rst = 1'b1; cyc(1);
  endtask

  logic [NR-1:0] gseq[16];
  int            ng, nb, n;
  logic [NR-1:0] prev;

  initial begin
    rst = 1'b0; init = 1'b0;
    // T1: both requesters valid while held in reset
    load_pkt(0, 2, 64'h100, 0, 0);
    load_pkt(1, 2, 64'h200, 0, 0);
    cyc(3);
    chk("t1_m_tvalid", m_tvalid, 0);
    chk("t1_tready", s_tready, 0);
    chk("t1_grant", o_grant, 0);
    chk("t1_cnt", o_pkt_cnt, 0);
    flush = 1'b1; cyc(2); flush = 1'b0;
    rst = 1'b1; cyc(1);

    // T2: link gate, then 3-beat packet from req0
    load_pkt(0, 3, 64'hA0, 0, 0);
    cyc(20);
    chk("t2_gate_grant", o_grant, 0);
    chk("t2_gate_busy", o_busy, 0);
    init = 1'b1;
    cyc(1);
    chk("t2_grant", o_grant, 2'b01);
    chk("t2_beat0", m_tdata, 64'hA0);
    drain("t2", 50);
    chk("t2_cnt0", o_pkt_cnt[CW-1:0], 1);

    // T3: round robin with continuous 2-beat packets
    do_reset();
    for (int k = 0; k < 5; k++) begin
      load_pkt(0, 2, 64'h300 + 64'(k*16), 0, 0);
      load_pkt(1, 2, 64'h400 + 64'(k*16), 0, 0);
    end
    ng = 0; prev = '0; n = 0;
    while ((expq[0].size() + expq[1].size() > 0 || m_owner >= 0) && n < 300) begin
      if (o_grant != 0 && prev == 0 && ng < 16) begin gseq[ng] = o_grant; ng++; end
      prev = o_grant;
      cyc(1); n++;
    end
    chk("t3_ngrants", ng, 10);
    chk("t3_g0", gseq[0], 2'b01);
    chk("t3_g1", gseq[1], 2'b10);
    chk("t3_g2", gseq[2], 2'b01);
    chk("t3_g3", gseq[3], 2'b10);
    chk("t3_cnt", o_pkt_cnt, 8'h55);

    // T4: req0 stalls mid-packet while req1 waits; grant must not move
    load_pkt(0, 4, 64'h500, 0, 5);
    load_pkt(1, 2, 64'h600, 0, 0);
    wait_grant("t4a", 20);
    chk("t4_first_grant", o_grant, 2'b01);
    nb = 0; n = 0;
    while (expq[0].size() > 0 && n < 100) begin
      if (o_grant !== 2'b01) nb++;
      cyc(1); n++;
    end
    chk("t4_lock_violations", nb, 0);
    wait_grant("t4b", 20);
    chk("t4_second_grant", o_grant, 2'b10);
    drain("t4", 50);

    // Random traffic: random lengths, gaps, 50% tready, flickering port init
    ready_pct = 50;
    for (int k = 0; k < 12; k++)
      for (int r = 0; r < NR; r++)
        load_pkt(r, int'($urandom_range(5, 1)), 64'h1000 * (r + 1) + 64'(k*16), 2,
                 int'($urandom_range(4)));
    n = 0;
    while ((expq[0].size() + expq[1].size() > 0 || m_owner >= 0) && n < 3000) begin
      init = ($urandom_range(3) != 0);
      cyc(1); n++;
    end
    init = 1'b1;
    drain("rand", 200);
    ready_pct = 100;

    // T5: counter wrap with CNT_W=4
    do_reset();
    for (int k = 0; k < 17; k++) load_pkt(1, 2, 64'h2000 + 64'(k*16), 0, 0);
    drain("t5", 300);
    chk("t5_cnt1", o_pkt_cnt[2*CW-1:CW], 1);
    chk("t5_cnt0", o_pkt_cnt[CW-1:0], 0);

    // T6: reset after beat 1 of 4, then a fresh packet from req1
    do_reset();
    load_pkt(0, 4, 64'h3000, 0, 0);
    n = 0;
    while (expq[0].size() > 3 && n < 30) begin cyc(1); n++; end
    chk("t6_wait_beat1", expq[0].size(), 3);
    rst = 1'b0;
    #1;
    chk("t6_m_tvalid", m_tvalid, 0);
    chk("t6_grant", o_grant, 0);
    chk("t6_busy", o_busy, 0);
    chk("t6_tready", s_tready, 0);
    flush = 1'b1; cyc(2); flush = 1'b0;
    rst = 1'b1; cyc(1);
    load_pkt(1, 2, 64'h3100, 0, 0);
    wait_grant("t6", 20);
    chk("t6_new_grant", o_grant, 2'b10);
    drain("t6", 50);
    chk("t6_cnt1", o_pkt_cnt[2*CW-1:CW], 1);
    chk("t6_cnt0", o_pkt_cnt[CW-1:0], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
